// File: rtl/tdc_sample_ctrl.sv
// rtl/tdc_sample_ctrl.sv - TDC measurement sequencer: arm, settle, pop-count sample, burst average
module tdc_sample_ctrl #(
    parameter int N        = 64,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 255,
    localparam int W       = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    input  logic         hit,
    output logic         arm,
    output logic         pc_en,
    input  logic [W-1:0] pc_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_timeout
);

    localparam int AW = W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = 4;

    localparam logic [CW-1:0] SMP_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_SAMPLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] smp_cnt;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] set_cnt;
    logic          to_flag;

    assign acc_sum = acc + AW'(pc_y);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_ARM;
            S_ARM: begin
                if (hit)                  state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                else if (to_cnt == TO_MAX) state_nxt = S_DONE;
            end
            S_SETTLE:  if (set_cnt == SET_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (smp_cnt == SMP_LAST) ? S_DONE : S_ARM;
            S_DONE:    if (res_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The result is latched on entry to DONE so it holds steady through any backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            smp_cnt  <= '0;
            to_cnt   <= '0;
            set_cnt  <= '0;
            to_flag  <= 1'b0;
            res_data <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                acc     <= '0;
                smp_cnt <= '0;
                to_flag <= 1'b0;
            end

            if (state != S_ARM) begin
                to_cnt <= '0;
            end else if (!hit) begin
                if (to_cnt == TO_MAX) begin
                    to_flag  <= 1'b1;
                    res_data <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end

            if (state != S_SETTLE) begin
                set_cnt <= '0;
            end else begin
                set_cnt <= set_cnt + SW'(1);
            end

            if (state == S_CAPTURE) begin
                acc <= acc_sum;
                if (smp_cnt == SMP_LAST) begin
                    res_data <= acc_sum[AW-1:AVG_LOG2];
                end else begin
                    smp_cnt <= smp_cnt + CW'(1);
                end
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign arm         = (state == S_ARM);
    assign pc_en       = (state == S_SAMPLE);
    assign res_valid   = (state == S_DONE);
    assign res_timeout = to_flag;

endmodule

// File: tb/tb_tdc_sample_ctrl.sv
// tb/tb_tdc_sample_ctrl.sv - scoreboard bench for tdc_sample_ctrl
module tb_tdc_sample_ctrl;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         hit;
    logic         arm;
    logic         pc_en;
    logic [W-1:0] pc_y;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_timeout;

    tdc_sample_ctrl #(
        .N(64), .AVG_LOG2(2), .SETTLE(2), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .hit(hit), .arm(arm),
        .pc_en(pc_en), .pc_y(pc_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         to;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           pc_cnt = 0;
    int           pc_multi = 0;
    logic         pc_prev = 1'b0;
    logic [W-1:0] y_vals[4];
    int           hit_dly[4];

    always @(negedge clk) begin
        if (pc_en === 1'b1) begin
            pc_cnt++;
            if (pc_prev === 1'b1) pc_multi++;
        end
        pc_prev = pc_en;
    end

    task automatic push_exp(input int sum, input logic to);
        exp_t e;
        e.data = to ? '0 : W'(sum >> 2);
        e.to   = to;
        sb.push_back(e);
    endtask

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (arm !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: arm=%b busy=%b expected 1 1", arm, busy);
        end
    endtask

    task automatic do_sample(input int i);
        int n = 0;
        while (arm !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (arm !== 1'b1) begin
            errors++;
            $display("FAIL arm_wait[%0d]: arm=%b expected 1", i, arm);
        end
        repeat (hit_dly[i]) @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        checks++;
        if (arm !== 1'b0) begin
            errors++;
            $display("FAIL hit_accept[%0d]: arm=%b expected 0", i, arm);
        end
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b0) begin
            errors++;
            $display("FAIL pc_en_early[%0d]: pc_en=%b expected 0", i, pc_en);
        end
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL pc_en_timing[%0d]: pc_en=%b expected 1", i, pc_en);
        end
        pc_y = W'($urandom_range(0, 127));
        @(negedge clk);
        pc_y = y_vals[i];
        @(negedge clk);
        pc_y = W'($urandom_range(0, 127));
    endtask

    task automatic wait_valid;
        int n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL res_valid_wait: res_valid=%b expected 1", res_valid);
        end
    endtask

    task automatic finish_burst;
        exp_t e;
        wait_valid();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: size=0 expected >0");
        end else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_timeout !== e.to) begin
                errors++;
                $display("FAIL result: data=%0d to=%b expected data=%0d to=%b",
                         res_data, res_timeout, e.data, e.to);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: busy=%b res_valid=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, arm, pc_en, res_valid, res_timeout} !== 5'b0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_state: outs=%b data=%0d expected 0",
                     {busy, arm, pc_en, res_valid, res_timeout}, res_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_average;
        int pc0 = pc_cnt;
        int m0 = pc_multi;
        y_vals = '{W'(10), W'(11), W'(12), W'(13)};
        hit_dly = '{3, 3, 3, 3};
        push_exp(46, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_sample(i);
        finish_burst();
        checks++;
        if (pc_cnt - pc0 != 4 || pc_multi != m0) begin
            errors++;
            $display("FAIL pc_en_pulses: count=%0d multi=%0d expected 4 0", pc_cnt - pc0, pc_multi - m0);
        end
    endtask

    task automatic test_no_overflow;
        y_vals = '{W'(64), W'(64), W'(64), W'(64)};
        hit_dly = '{3, 3, 3, 3};
        push_exp(256, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_sample(i);
        finish_burst();
    endtask

    task automatic test_timeout;
        int pc0 = pc_cnt;
        int n = 0;
        push_exp(0, 1'b1);
        do_start();
        while (arm === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_arm_cycles: got %0d expected 16", n);
        end
        finish_burst();
        checks++;
        if (pc_cnt != pc0) begin
            errors++;
            $display("FAIL timeout_pc_en: pulses=%0d expected 0", pc_cnt - pc0);
        end
    endtask

    task automatic test_late_hit;
        y_vals = '{W'(1), W'(2), W'(3), W'(4)};
        hit_dly = '{15, 0, 0, 0};
        push_exp(10, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_sample(i);
        finish_burst();
    endtask

    task automatic test_backpressure;
        exp_t e;
        y_vals = '{W'(20), W'(21), W'(22), W'(23)};
        hit_dly = '{1, 0, 2, 0};
        push_exp(86, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_sample(i);
        wait_valid();
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            hit   = k[0];
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== e.data || res_timeout !== e.to || arm !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b data=%0d to=%b arm=%b expected 1 %0d %b 0",
                         k, res_valid, res_data, res_timeout, arm, e.data, e.to);
            end
        end
        start = 1'b0;
        hit = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: busy=%b valid=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        y_vals = '{W'(9), W'(9), W'(9), W'(9)};
        hit_dly = '{0, 0, 0, 0};
        do_start();
        do_sample(0);
        while (arm !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, arm, pc_en, res_valid, res_timeout} !== 5'b0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_burst: outs=%b data=%0d expected 0",
                     {busy, arm, pc_en, res_valid, res_timeout}, res_data);
        end
        @(negedge clk);
        rst = 1'b0;
        y_vals = '{W'(4), W'(4), W'(4), W'(4)};
        push_exp(16, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) do_sample(i);
        finish_burst();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: size=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        hit = 1'b0;
        res_ready = 1'b0;
        pc_y = '0;
        test_reset();
        test_average();
        test_no_overflow();
        test_timeout();
        test_late_hit();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tdc_sample_ctrl.md
# tdc_sample_ctrl

Measurement sequencer for the TDC capture path. It arms the delay line and waits for the stop hit. After a settle window it pulses the pop-count output-register enable, then accumulates 2^AVG_LOG2 pop-count results and returns their truncated mean over a valid/ready handshake. It sits between the host/readout logic and the pop-count stage of the TDC.

## Interface
- N, 64: delay-line taps and pop-count input width. W = $clog2(N)+1.
- AVG_LOG2, 2: samples per burst = 2^AVG_LOG2. Range 0..4.
- SETTLE, 2: idle cycles between accepted hit and pop-count enable. Range 0..15.
- TIMEOUT, 255: ARM cycles allowed without a hit before the burst aborts. Must be ≥1.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- hit  in  1  synchronized stop event; delay-line code is frozen once asserted.
- arm  out  1  delay-line capture enable; high only in ARM.
- pc_en  out  1  pop-count register enable; high only in SAMPLE.
- pc_y  in  W  pop-count result; valid the cycle after pc_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  mean = accumulator >> AVG_LOG2, truncated.
- res_timeout  out  1  burst aborted by timeout; qualifies res_data.

## Operation
- States: IDLE, ARM, SETTLE, SAMPLE, CAPTURE, DONE.
- IDLE: when start=1, go to ARM. Clear the accumulator (W+AVG_LOG2 bits), the sample counter (AVG_LOG2 bits) and the timeout flag.
- ARM: arm=1. The timeout counter ($clog2(TIMEOUT+1) bits) clears on ARM entry and increments on each ARM cycle with hit=0.
  - If hit=1: go to SETTLE, or to SAMPLE when SETTLE=0.
  - Else if the counter equals TIMEOUT: set the timeout flag and go to DONE.
  - Hit takes priority when both conditions hold in the same cycle.
- SETTLE: stays for exactly SETTLE cycles, then goes to SAMPLE.
- SAMPLE: pc_en=1 for one cycle, then go to CAPTURE.
- CAPTURE: accumulator += pc_y, zero-extended. Then:
  - if the sample counter equals 2^AVG_LOG2−1, go to DONE;
  - otherwise increment the counter and go to ARM.
- DONE: res_valid=1, and res_data and res_timeout are held stable. When res_valid && res_ready, go to IDLE.
- Outputs on timeout: res_data=0 and res_timeout=1, regardless of any samples already accumulated.
- The accumulator cannot overflow: 2^AVG_LOG2·N < 2^(W+AVG_LOG2).
- Inputs that are ignored:
  - start outside IDLE;
  - hit outside ARM;
  - pc_y outside CAPTURE.
- Reset, asynchronous at any time including mid-burst:
  - state goes to IDLE;
  - busy, arm, pc_en, res_valid and res_timeout go to 0;
  - res_data goes to 0;
  - counters and accumulator go to 0.
  - No partial result is produced after reset.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Burst start: start=1 in IDLE at edge k gives arm=1 and busy=1 from k+1.
- Per sample, with hit seen in the first ARM cycle:
  - ARM 1 cycle;
  - SETTLE S cycles;
  - SAMPLE 1 cycle;
  - CAPTURE 1 cycle.
  - Total S+3 cycles.
- pc_en is high at edge j. pc_y is consumed at edge j+1, matching the pop-count 1-cycle register latency.
- Full burst, no hit wait, from start to res_valid: 1 + 2^AVG_LOG2·(S+3) cycles.
- Worst-case ARM dwell is TIMEOUT+1 cycles.
- Back-to-back bursts: the handshake completes at edge m and IDLE is entered at m+1. A start sampled at m+1 re-arms at m+2.

## Test plan
- N=64, AVG_LOG2=2, SETTLE=2, TIMEOUT=15. Start, then a hit 3 cycles after each arm. pc_y = 10, 11, 12, 13.
  - Required: res_data=11 (46>>2), res_timeout=0.
  - Required: exactly 4 single-cycle pc_en pulses, each 2 cycles after its hit.
- Same config, pc_y=64 for all four samples.
  - Required: res_data=64, proving no accumulator overflow.
- Same config, no hit ever.
  - Required: arm stays high for exactly 16 cycles.
  - Required: res_valid=1, res_timeout=1, res_data=0, and pc_en is never asserted.
- Hit held on the final ARM cycle (counter=15).
  - Required: the sample is accepted and no timeout occurs.
- Backpressure: res_ready=0 for 5 cycles in DONE, with start pulsed and hit toggled during that window.
  - Required: res_valid, res_data and res_timeout stay stable.
  - Required: state stays in DONE and arm=0.
  - Required: IDLE is entered the cycle after res_ready=1.
- Reset pulse in SETTLE of sample 2.
  - Required: all outputs are 0 immediately.
  - Required: the next burst, with pc_y = 4, 4, 4, 4, returns res_data=4, with no carry-over from the aborted burst.
